// File: rtl/ldpc_frame_io_ctrl.sv
// Frame I/O sequencer for the LDPC decoder: scatters intrinsic LLRs into the PE memories,
// runs the decoder until its frame id toggles (or times out), then streams hard decisions.
module ldpc_frame_io_ctrl #(
  parameter int unsigned L             = 32,
  parameter int unsigned K             = 6,
  parameter int unsigned MESSAGE_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH    = $clog2(L),
  parameter int unsigned RD_LAT        = 2,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MESSAGE_WIDTH-1:0] in_data,
  output logic [MESSAGE_WIDTH-1:0] int_out,
  output logic [K*K-1:0]           pe_select,
  output logic [ADDR_WIDTH-1:0]    load_add,
  output logic                     load_we,
  output logic                     ext_reset,
  output logic                     dec_en,
  input  logic                     f_id,
  output logic [K-1:0]             column_select,
  output logic [ADDR_WIDTH-1:0]    read_add,
  input  logic [K*K-1:0]           dec_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [K*K-1:0]           out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              frame_count
);

  localparam int unsigned PeW        = K * K;
  localparam int unsigned NumSamples = L * K * K;
  localparam int unsigned SampW      = $clog2(NumSamples);
  localparam int unsigned TmoW       = $clog2(TIMEOUT + 1);
  localparam int unsigned LatW       = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDecode, StSweep, StRwait, StOhold} state_e;

  state_e                   state_q;
  logic [SampW-1:0]         samp_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [PeW-1:0]           pe_oh_q;
  logic [TmoW-1:0]          tmo_q;
  logic [LatW-1:0]          lat_q;
  logic                     prev_fid_q;
  logic [K-1:0]             col_q;
  logic [ADDR_WIDTH-1:0]    rd_add_q;
  logic                     in_ready_q;
  logic [MESSAGE_WIDTH-1:0] int_out_q;
  logic [PeW-1:0]           pe_sel_q;
  logic [ADDR_WIDTH-1:0]    load_add_q;
  logic                     load_we_q;
  logic                     ext_reset_q;
  logic                     dec_en_q;
  logic                     out_valid_q;
  logic [PeW-1:0]           out_data_q;
  logic                     out_last_q;
  logic                     busy_q;
  logic                     tmo_err_q;
  logic [15:0]              frame_cnt_q;
  logic                     accept;

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      samp_q      <= '0;
      addr_q      <= '0;
      pe_oh_q     <= '0;
      tmo_q       <= '0;
      lat_q       <= '0;
      prev_fid_q  <= 1'b0;
      col_q       <= '0;
      rd_add_q    <= '0;
      in_ready_q  <= 1'b0;
      int_out_q   <= '0;
      pe_sel_q    <= '0;
      load_add_q  <= '0;
      load_we_q   <= 1'b0;
      ext_reset_q <= 1'b0;
      dec_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // Write strobe follows acceptance by one cycle; gaps drop strobe and select together.
      load_we_q   <= accept;
      pe_sel_q    <= accept ? pe_oh_q : '0;
      ext_reset_q <= 1'b0;
      if (accept) begin
        int_out_q  <= in_data;
        load_add_q <= addr_q;
        samp_q     <= samp_q + SampW'(1);
        if (addr_q == ADDR_WIDTH'(L - 1)) begin
          addr_q  <= '0;
          pe_oh_q <= pe_oh_q << 1;
        end else begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q     <= StLoad;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            ext_reset_q <= 1'b1;
            tmo_err_q   <= 1'b0;
            samp_q      <= '0;
            addr_q      <= '0;
            pe_oh_q     <= PeW'(1);
          end
        end
        StLoad: begin
          if (accept && (samp_q == SampW'(NumSamples - 1))) begin
            state_q    <= StDecode;
            in_ready_q <= 1'b0;
            dec_en_q   <= 1'b1;
            prev_fid_q <= f_id;
            tmo_q      <= '0;
          end
        end
        StDecode: begin
          // A toggle on the final timeout cycle still counts as success.
          if (f_id != prev_fid_q) begin
            state_q  <= StSweep;
            col_q    <= K'(1);
            rd_add_q <= '0;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_q   <= StIdle;
            tmo_err_q <= 1'b1;
            dec_en_q  <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StSweep: begin
          if (col_q[K-1]) begin
            col_q   <= '0;
            lat_q   <= '0;
            state_q <= StRwait;
          end else begin
            col_q <= col_q << 1;
          end
        end
        StRwait: begin
          if (lat_q == LatW'(RD_LAT - 1)) begin
            out_data_q  <= dec_in;
            out_last_q  <= (rd_add_q == ADDR_WIDTH'(L - 1));
            out_valid_q <= 1'b1;
            state_q     <= StOhold;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StOhold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (rd_add_q == ADDR_WIDTH'(L - 1)) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              dec_en_q    <= 1'b0;
              busy_q      <= 1'b0;
              rd_add_q    <= '0;
              state_q     <= StIdle;
            end else begin
              rd_add_q <= rd_add_q + ADDR_WIDTH'(1);
              col_q    <= K'(1);
              state_q  <= StSweep;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign int_out       = int_out_q;
  assign pe_select     = pe_sel_q;
  assign load_add      = load_add_q;
  assign load_we       = load_we_q;
  assign ext_reset     = ext_reset_q;
  assign dec_en        = dec_en_q;
  assign column_select = col_q;
  assign read_add      = rd_add_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_err_q;
  assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_ldpc_frame_io_ctrl.sv
// Directed bench for ldpc_frame_io_ctrl: load mapping, decode handshake, backpressure,
// timeout and asynchronous reset, with a small decoder read-latency model.
module tb_ldpc_frame_io_ctrl;

  localparam int NS = 1152;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_data = '0;
  logic [4:0]  int_out;
  logic [35:0] pe_select;
  logic [4:0]  load_add;
  logic        load_we;
  logic        ext_reset;
  logic        dec_en;
  logic        f_id = 1'b0;
  logic [5:0]  column_select;
  logic [4:0]  read_add;
  logic [35:0] dec_in;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [35:0] out_data;
  logic        out_last;
  logic        busy;
  logic        timeout_err;
  logic [15:0] frame_count;

  ldpc_frame_io_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .int_out       (int_out),
    .pe_select     (pe_select),
    .load_add      (load_add),
    .load_we       (load_we),
    .ext_reset     (ext_reset),
    .dec_en        (dec_en),
    .f_id          (f_id),
    .column_select (column_select),
    .read_add      (read_add),
    .dec_in        (dec_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pat(input logic [4:0] r);
    return {26'b0, r, 5'd31 - r};
  endfunction

  function automatic logic [4:0] dat(input int m, input int n);
    return (m == 0) ? 5'(n % 32) : 5'((n * 7 + 3) % 32);
  endfunction

  // Decoder model: hard decisions are valid only RD_LAT=2 cycles after the last column.
  logic [1:0] sr = '0;
  always @(posedge clk) sr <= {sr[0], column_select[5]};
  assign dec_in = sr[1] ? pat(read_add) : ~pat(read_add);

  int mode = 0;
  int ld_n = 0;
  int ext_cnt = 0;
  int dec_cycles = 0;
  logic [35:0] sp_pe0, sp_pe32, sp_pe1151;
  logic [4:0]  sp_ad0, sp_ad32, sp_ad1151;

  always @(negedge clk) begin
    if (ext_reset) begin
      ext_cnt++;
      ld_n = 0;
    end
    if (dec_en) dec_cycles++;
    if (load_we) begin
      check("ld_pe", pe_select, 64'(1) << (ld_n / 32));
      check("ld_addr", load_add, 64'(ld_n % 32));
      check("ld_data", int_out, dat(mode, ld_n));
      if (ld_n == 0) begin sp_pe0 = pe_select; sp_ad0 = load_add; end
      if (ld_n == 32) begin sp_pe32 = pe_select; sp_ad32 = load_add; end
      if (ld_n == 1151) begin sp_pe1151 = pe_select; sp_ad1151 = load_add; end
      ld_n++;
    end else if (!reset) begin
      check("gap_pe", pe_select, 0);
    end
  end

  task automatic load_frame(input bit gaps, input int nmax);
    int n = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (n < nmax && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      ph = ~ph;
      in_valid = !gaps || ph;
      in_data = dat(mode, n);
      if (in_valid && in_ready) n++;
    end
    check("load_done", 64'(n), 64'(nmax));
    if (nmax == NS) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic unload(input int stall_word);
    int k = 0;
    int cyc = 0;
    int st = 0;
    int sc = 0;
    out_ready = 1'b1;
    while (k < 32 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (column_select != 0) begin
        check("col_seq", column_select, 64'(1) << sc);
        check("rd_addr", read_add, 64'(k));
        sc = (sc + 1) % 6;
      end
      if (out_valid) begin
        if (k == stall_word && st < 10) begin
          check("bp_data", out_data, pat(5'(k)));
          check("bp_col", column_select, 0);
          out_ready = 1'b0;
          st++;
        end else begin
          out_ready = 1'b1;
          check("word", out_data, pat(5'(k)));
          check("last", out_last, 64'(k == 31));
          k++;
        end
      end
    end
    check("words", 64'(k), 32);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int d0;
  int cyc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pe", pe_select, 0);
    check("rst_dec_en", dec_en, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_frames", frame_count, 0);
    check("idle_tmo", timeout_err, 0);

    // Asynchronous reset in the middle of a load
    mode = 0;
    load_frame(1'b0, 500);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_pe", pe_select, 0);
    check("arst_we", load_we, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_int_out", int_out, 0);
    check("arst_add", load_add, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_pe", pe_select, 0);

    // Frame A: back-to-back load, decode done after ~100 cycles, stall on word 5
    mode = 0;
    load_frame(1'b0, NS);
    @(negedge clk);
    check("A_ld_count", 64'(ld_n), NS);
    check("A_ext_cnt", 64'(ext_cnt), 2);
    check("A_dec_en", dec_en, 1);
    check("A_in_ready", in_ready, 0);
    check("A_busy", busy, 1);
    check("sp_pe0", sp_pe0, 36'h1);
    check("sp_ad0", sp_ad0, 0);
    check("sp_pe32", sp_pe32, 36'h2);
    check("sp_ad32", sp_ad32, 0);
    check("sp_pe1151", sp_pe1151, 36'h8_0000_0000);
    check("sp_ad1151", sp_ad1151, 31);
    repeat (98) @(negedge clk);
    check("A_decode_wait", out_valid, 0);
    f_id = ~f_id;
    unload(5);
    check("A_frames", frame_count, 1);
    check("A_dec_en_off", dec_en, 0);
    check("A_busy_off", busy, 0);
    check("A_out_valid", out_valid, 0);

    // Frame B: gapped load, decoder never finishes
    mode = 1;
    d0 = dec_cycles;
    load_frame(1'b1, NS);
    @(negedge clk);
    check("B_ld_count", 64'(ld_n), NS);
    check("B_ext_cnt", 64'(ext_cnt), 3);
    cyc = 0;
    while (busy && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("B_tmo_wait", busy, 0);
    @(negedge clk);
    check("B_tmo_err", timeout_err, 1);
    check("B_dec_en", dec_en, 0);
    check("B_frames", frame_count, 1);
    check("B_dec_cycles", 64'(dec_cycles - d0), 4096);
    check("B_out_valid", out_valid, 0);

    // Frame C: new frame clears timeout_err, f_id toggles back to 0
    mode = 0;
    load_frame(1'b0, NS);
    @(negedge clk);
    check("C_tmo_cleared", timeout_err, 0);
    check("C_ext_cnt", 64'(ext_cnt), 4);
    check("C_ld_count", 64'(ld_n), NS);
    repeat (5) @(negedge clk);
    f_id = ~f_id;
    unload(-1);
    check("C_frames", frame_count, 2);
    check("C_busy_off", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
